// File: rtl/uart_pkg.sv
// Shared types and helpers for uart_core: bit-period rounding, counter sizing, FSM state enums.
package uart_pkg;

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

  // Clock cycles per bit, rounded to nearest.
  function automatic int bit_cycles(input int clk_freq, input int baud_rate);
    return (clk_freq + baud_rate / 2) / baud_rate;
  endfunction

  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int DFLT_BIT_CYC = bit_cycles(100_000_000, 921_600);
  localparam int DFLT_CNT_W   = cnt_width(DFLT_BIT_CYC);

endpackage

// File: rtl/uart_majority_filter.sv
// M_TAPS-deep shift register whose registered majority value is the filtered rx line (idles high).
module uart_majority_filter #(
  parameter int M_TAPS = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [M_TAPS-1:0] r_taps;
  logic              r_maj;
  logic              w_maj;

  assign w_maj = ($countones(r_taps) > (M_TAPS / 2));
  assign dout  = r_maj;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_taps <= '1;
      r_maj  <= 1'b1;
    end else begin
      r_taps <= M_TAPS'({r_taps, din});
      r_maj  <= w_maj;
    end
  end

endmodule

// File: rtl/uart_core.sv
// Full-duplex UART: ready/valid TX serialiser and majority-filtered RX deserialiser.
// Define UART_LOOPBACK_EN to feed the receiver from the tx register instead of the rx pin.
module uart_core
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 921_600,
  parameter int PARITY    = 0,
  parameter int DI_WIDTH  = 8,
  parameter int DO_WIDTH  = 8,
  parameter int M_TAPS    = 3
) (
  input  logic                clk,
  input  logic                rst,
  output logic                rfd,
  input  logic [DI_WIDTH-1:0] din,
  input  logic                din_vld,
  output logic                tx,
  input  logic                rx,
  output logic [DO_WIDTH-1:0] dout,
  output logic                dout_vld,
  output logic                rx_err
);

  localparam int BIT_CYC = bit_cycles(CLK_FREQ, BAUD_RATE);
  localparam int CNT_W   = cnt_width(BIT_CYC);
  localparam int TBW     = cnt_width(DI_WIDTH);
  localparam int RBW     = cnt_width(DO_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BIT_CYC / 2 - 1);
  localparam logic [TBW-1:0]   TB_LAST  = TBW'(DI_WIDTH - 1);
  localparam logic [RBW-1:0]   RB_LAST  = RBW'(DO_WIDTH - 1);

  // ---------------- transmitter ----------------
  tx_state_t           r_tx_st;
  logic [CNT_W-1:0]    r_tx_cnt;
  logic [TBW-1:0]      r_tx_bit;
  logic [DI_WIDTH-1:0] r_tx_sh;
  logic                r_tx_par;
  logic                r_tx;
  logic                r_rfd;

  assign tx  = r_tx;
  assign rfd = r_rfd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_st  <= TX_IDLE;
      r_tx_cnt <= '0;
      r_tx_bit <= '0;
      r_tx_sh  <= '0;
      r_tx_par <= 1'b0;
      r_tx     <= 1'b1;
      r_rfd    <= 1'b1;
    end else if (r_tx_st == TX_IDLE) begin
      if (din_vld) begin
        r_tx_sh  <= din;
        r_tx_par <= ^din;
        r_tx     <= 1'b0;
        r_rfd    <= 1'b0;
        r_tx_cnt <= '0;
        r_tx_bit <= '0;
        r_tx_st  <= TX_START;
      end
    end else if (r_tx_cnt != CNT_LAST) begin
      r_tx_cnt <= r_tx_cnt + 1'b1;
    end else begin
      r_tx_cnt <= '0;
      case (r_tx_st)
        TX_START: begin
          r_tx    <= r_tx_sh[0];
          r_tx_sh <= r_tx_sh >> 1;
          r_tx_st <= TX_DATA;
        end
        TX_DATA: begin
          if (r_tx_bit != TB_LAST) begin
            r_tx_bit <= r_tx_bit + 1'b1;
            r_tx     <= r_tx_sh[0];
            r_tx_sh  <= r_tx_sh >> 1;
          end else if (PARITY != 0) begin
            r_tx    <= r_tx_par;
            r_tx_st <= TX_PARITY;
          end else begin
            r_tx    <= 1'b1;
            r_tx_st <= TX_STOP;
          end
        end
        TX_PARITY: begin
          r_tx    <= 1'b1;
          r_tx_st <= TX_STOP;
        end
        default: begin
          r_rfd   <= 1'b1;
          r_tx_st <= TX_IDLE;
        end
      endcase
    end
  end

  // ---------------- receiver ----------------
  logic w_rx_in;
`ifdef UART_LOOPBACK_EN
  assign w_rx_in = r_tx;
`else
  assign w_rx_in = rx;
`endif

  logic [1:0] r_sync;
  logic       r_rf_d;
  logic       w_rf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '1;
      r_rf_d <= 1'b1;
    end else begin
      r_sync <= {r_sync[0], w_rx_in};
      r_rf_d <= w_rf;
    end
  end

  uart_majority_filter #(.M_TAPS(M_TAPS)) u_filt (
    .clk  (clk),
    .rst  (rst),
    .din  (r_sync[1]),
    .dout (w_rf)
  );

  rx_state_t           r_rx_st;
  logic [CNT_W-1:0]    r_rx_cnt;
  logic [RBW-1:0]      r_rx_bit;
  logic [DO_WIDTH-1:0] r_rx_sh;
  logic                r_rx_par;
  logic [DO_WIDTH-1:0] r_dout;
  logic                r_dout_vld;
  logic                r_rx_err;
  logic                w_par_ok;

  assign w_par_ok = (PARITY == 0) || ((^r_rx_sh) == r_rx_par);
  assign dout     = r_dout;
  assign dout_vld = r_dout_vld;
  assign rx_err   = r_rx_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_st    <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_sh    <= '0;
      r_rx_par   <= 1'b0;
      r_dout     <= '0;
      r_dout_vld <= 1'b0;
      r_rx_err   <= 1'b0;
    end else begin
      r_dout_vld <= 1'b0;
      r_rx_err   <= 1'b0;
      case (r_rx_st)
        RX_IDLE: begin
          if (r_rf_d && !w_rf) begin
            r_rx_cnt <= '0;
            r_rx_st  <= RX_START;
          end
        end
        RX_START: begin
          if (r_rx_cnt != CNT_HALF) begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end else begin
            // Line back high at mid-start means a glitch, not a frame.
            r_rx_cnt <= '0;
            r_rx_bit <= '0;
            r_rx_st  <= w_rf ? RX_IDLE : RX_DATA;
          end
        end
        default: begin
          if (r_rx_cnt != CNT_LAST) begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end else begin
            r_rx_cnt <= '0;
            case (r_rx_st)
              RX_DATA: begin
                r_rx_sh  <= {w_rf, r_rx_sh[DO_WIDTH-1:1]};
                r_rx_bit <= r_rx_bit + 1'b1;
                if (r_rx_bit == RB_LAST) r_rx_st <= (PARITY != 0) ? RX_PARITY : RX_STOP;
              end
              RX_PARITY: begin
                r_rx_par <= w_rf;
                r_rx_st  <= RX_STOP;
              end
              default: begin
                r_rx_st <= RX_IDLE;
                if (w_rf && w_par_ok) begin
                  r_dout     <= r_rx_sh;
                  r_dout_vld <= 1'b1;
                end else begin
                  r_rx_err <= 1'b1;
                end
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_core.sv
// Directed bench: two cross-connected no-parity UARTs plus a parity-enabled pair with line fault injection.
module tb_uart_core;

  localparam int BC = 109;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       a_rfd, a_tx, a_din_vld, a_dout_vld, a_rx_err;
  logic [7:0] a_din, a_dout;
  logic       b_rfd, b_tx, b_rx, b_dout_vld, b_rx_err;
  logic [7:0] b_dout;
  logic       pa_rfd, pa_tx, pa_din_vld, pa_dout_vld, pa_rx_err;
  logic [7:0] pa_din, pa_dout;
  logic       pb_rfd, pb_tx, pb_rx, pb_dout_vld, pb_rx_err;
  logic [7:0] pb_dout;
  logic       b_sel, b_drv, p_inv;
  logic [7:0] zero8 = 8'h00;
  logic       zero1 = 1'b0;

  assign b_rx  = b_sel ? b_drv : a_tx;
  assign pb_rx = pa_tx ^ p_inv;

  uart_core u_a (.clk(clk), .rst(rst), .rfd(a_rfd), .din(a_din), .din_vld(a_din_vld), .tx(a_tx),
                 .rx(b_tx), .dout(a_dout), .dout_vld(a_dout_vld), .rx_err(a_rx_err));
  uart_core u_b (.clk(clk), .rst(rst), .rfd(b_rfd), .din(zero8), .din_vld(zero1), .tx(b_tx),
                 .rx(b_rx), .dout(b_dout), .dout_vld(b_dout_vld), .rx_err(b_rx_err));
  uart_core #(.PARITY(1)) u_pa (.clk(clk), .rst(rst), .rfd(pa_rfd), .din(pa_din), .din_vld(pa_din_vld),
                 .tx(pa_tx), .rx(pb_tx), .dout(pa_dout), .dout_vld(pa_dout_vld), .rx_err(pa_rx_err));
  uart_core #(.PARITY(1)) u_pb (.clk(clk), .rst(rst), .rfd(pb_rfd), .din(zero8), .din_vld(zero1),
                 .tx(pb_tx), .rx(pb_rx), .dout(pb_dout), .dout_vld(pb_dout_vld), .rx_err(pb_rx_err));

  int cyc = 0;
  int b_vld_n = 0, b_err_n = 0, b_vld_cyc = 0, b_both = 0;
  int pb_vld_n = 0, pb_err_n = 0, pb_both = 0;
  int checks = 0, errors = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (b_dout_vld) begin b_vld_n <= b_vld_n + 1; b_vld_cyc <= cyc; end
    if (b_rx_err) b_err_n <= b_err_n + 1;
    if (b_dout_vld && b_rx_err) b_both <= b_both + 1;
    if (pb_dout_vld) pb_vld_n <= pb_vld_n + 1;
    if (pb_rx_err) pb_err_n <= pb_err_n + 1;
    if (pb_dout_vld && pb_rx_err) pb_both <= pb_both + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_b(input logic [7:0] d, input logic stop);
    b_drv = 1'b0; repeat (BC) @(negedge clk);
    for (int i = 0; i < 8; i++) begin b_drv = d[i]; repeat (BC) @(negedge clk); end
    b_drv = stop; repeat (BC) @(negedge clk);
    b_drv = 1'b1; repeat (2 * BC) @(negedge clk);
  endtask

  logic [9:0]  fr;
  logic [10:0] fp;
  int e_cyc, lat, v0, e0, pv0, pe0, rfd_n;

  initial begin
    a_din = 8'h00; a_din_vld = 1'b0; pa_din = 8'h00; pa_din_vld = 1'b0;
    b_sel = 1'b0; b_drv = 1'b1; p_inv = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_tx", a_tx, 1);
    chk("rst_rfd", a_rfd, 1);
    chk("rst_dout_vld", b_dout_vld, 0);
    chk("rst_rx_err", b_rx_err, 0);
    chk("rst_dout", b_dout, 0);

    // Single frame 100 = 0x64, sampled at each bit centre
    a_din = 8'd100; a_din_vld = 1'b1;
    @(posedge clk); @(negedge clk);
    a_din_vld = 1'b0; a_din = 8'hFF; e_cyc = cyc;
    chk("rfd_drop", a_rfd, 0);
    fr = {1'b1, 8'd100, 1'b0};
    repeat (54) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("tx_bit%0d", k), a_tx, fr[k]);
      if (k < 9) repeat (BC) @(negedge clk);
    end
    repeat (54) @(negedge clk);
    chk("rfd_stop_end", a_rfd, 0);
    @(negedge clk);
    chk("rfd_rise", a_rfd, 1);
    chk("rx1_vld_n", b_vld_n, 1);
    chk("rx1_dout", b_dout, 100);
    lat = b_vld_cyc - e_cyc;
    chk("rx1_latency_win", (lat >= 1020 && lat <= 1060), 1);

    // Back-to-back: din_vld held for three frames
    v0 = b_vld_n; rfd_n = 0;
    a_din = 8'd100; a_din_vld = 1'b1;
    for (int i = 0; i < 3 * (10 * BC + 1); i++) begin
      if (a_rfd) rfd_n++;
      @(negedge clk);
    end
    a_din_vld = 1'b0;
    chk("b2b_rfd_cycles", rfd_n, 3);
    chk("b2b_vld_n", b_vld_n - v0, 3);
    chk("b2b_dout", b_dout, 100);
    chk("b2b_err_n", b_err_n, 0);

    // Parity frame 0x07: parity bit 1
    pa_din = 8'h07; pa_din_vld = 1'b1;
    @(posedge clk); @(negedge clk);
    pa_din_vld = 1'b0;
    fp = {1'b1, 1'b1, 8'h07, 1'b0};
    repeat (54) @(negedge clk);
    for (int k = 0; k < 11; k++) begin
      chk($sformatf("ptx_bit%0d", k), pa_tx, fp[k]);
      if (k < 10) repeat (BC) @(negedge clk);
    end
    repeat (120) @(negedge clk);
    chk("par_vld_n", pb_vld_n, 1);
    chk("par_dout", pb_dout, 8'h07);
    chk("par_err_n", pb_err_n, 0);

    // Parity frame 0x0F with parity bit inverted on the line
    pa_din = 8'h0F; pa_din_vld = 1'b1;
    @(posedge clk); @(negedge clk);
    pa_din_vld = 1'b0;
    repeat (9 * BC) @(negedge clk);
    p_inv = 1'b1;
    repeat (BC - 1) @(negedge clk);
    p_inv = 1'b0;
    repeat (200) @(negedge clk);
    chk("badpar_err_n", pb_err_n, 1);
    chk("badpar_vld_n", pb_vld_n, 1);
    chk("badpar_dout_kept", pb_dout, 8'h07);

    // Stop bit forced low, then a good frame
    b_sel = 1'b1; b_drv = 1'b1;
    repeat (10) @(negedge clk);
    v0 = b_vld_n; e0 = b_err_n;
    send_b(8'hC3, 1'b0);
    chk("badstop_err", b_err_n - e0, 1);
    chk("badstop_vld", b_vld_n - v0, 0);
    chk("badstop_dout_kept", b_dout, 100);
    send_b(8'h5A, 1'b1);
    chk("after_bad_vld", b_vld_n - v0, 1);
    chk("after_bad_dout", b_dout, 8'h5A);
    chk("after_bad_err", b_err_n - e0, 1);

    // Glitches while idle: 1 cycle, then shorter than half a bit
    v0 = b_vld_n; e0 = b_err_n;
    b_drv = 1'b0; @(negedge clk); b_drv = 1'b1;
    repeat (300) @(negedge clk);
    chk("glitch1_vld", b_vld_n - v0, 0);
    chk("glitch1_err", b_err_n - e0, 0);
    b_drv = 1'b0; repeat (20) @(negedge clk); b_drv = 1'b1;
    repeat (300) @(negedge clk);
    chk("glitch20_vld", b_vld_n - v0, 0);
    chk("glitch20_err", b_err_n - e0, 0);
    b_sel = 1'b0;
    repeat (10) @(negedge clk);

    // Reset mid-frame while tx is driving a 0 data bit (0x33 bit 2)
    v0 = b_vld_n; e0 = b_err_n;
    a_din = 8'h33; a_din_vld = 1'b1;
    @(posedge clk); @(negedge clk);
    a_din_vld = 1'b0;
    repeat (400) @(negedge clk);
    chk("pre_rst_tx_low", a_tx, 0);
    rst = 1'b1;
    #1;
    chk("midrst_tx", a_tx, 1);
    chk("midrst_rfd", a_rfd, 1);
    chk("midrst_dout", b_dout, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    a_din = 8'hA5; a_din_vld = 1'b1;
    @(posedge clk); @(negedge clk);
    a_din_vld = 1'b0;
    repeat (10 * BC + 100) @(negedge clk);
    chk("post_rst_vld", b_vld_n - v0, 1);
    chk("post_rst_dout", b_dout, 8'hA5);
    chk("post_rst_err", b_err_n - e0, 0);
    chk("vld_err_exclusive", b_both + pb_both, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_core.md
Name: uart_core

Overview:
- Full-duplex asynchronous serial transceiver: an independent transmitter and receiver sharing one clock and reset.
- TX serialises a parallel word accepted through a ready/valid handshake.
- RX deserialises the rx line, filtered by a majority voter, into a one-cycle valid pulse with an error flag.
- Sits between fabric logic and the board-level serial pins; two instances cross-connected form a point-to-point link.

Parameters:
- CLK_FREQ, 100_000_000: input clock frequency, Hz.
- BAUD_RATE, 921_600: line bit rate, bit/s.
- PARITY, 0: 1 = even parity bit appended/checked; 0 = no parity bit.
- DI_WIDTH, 8: data bits per transmitted frame (din width).
- DO_WIDTH, 8: data bits per received frame (dout width).
- M_TAPS, 3: length of the rx majority filter; odd, ≥1.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- rfd  out  1  ready-for-data; TX idle and able to accept din.
- din  in  DI_WIDTH  word to transmit.
- din_vld  in  1  din valid.
- tx  out  1  serial output; idle high.
- rx  in  1  serial input; asynchronous to clk.
- dout  out  DO_WIDTH  last received word.
- dout_vld  out  1  one-cycle pulse, dout updated.
- rx_err  out  1  one-cycle pulse, bad frame received.

Behaviour:
- Bit period: BIT_CYC = (CLK_FREQ + BAUD_RATE/2) / BAUD_RATE, rounded to nearest. Default = 109 cycles.
- Frame format: start bit 0, data LSB first, parity (only if PARITY=1, XOR of data bits), then one stop bit 1.
- Reset values: tx=1, rfd=1, dout=0, dout_vld=0, rx_err=0. All counters are cleared and both FSMs go to IDLE.
- Reset mid-frame aborts the frame immediately; tx returns high asynchronously.
- TX FSM:
  - States: IDLE → START → DATA → [PARITY] → STOP → IDLE.
  - In IDLE, rfd=1. When din_vld=1 on a clock edge, din is latched, rfd drops on that edge, and tx goes 0 starting the next cycle.
  - Each state lasts exactly BIT_CYC cycles.
  - rfd rises again in the cycle after the stop bit completes.
  - din_vld held high gives back-to-back frames with no idle gap beyond that one rfd cycle.
  - din_vld while rfd=0 is ignored; din need not be held after acceptance.
- RX input conditioning:
  - rx passes through a 2-flop synchroniser.
  - Then an M_TAPS shift register whose majority value is the filtered line rf. rf resets to 1.
- RX FSM:
  - States: IDLE → START → DATA → [PARITY] → STOP → IDLE.
  - IDLE: a falling edge of rf starts the frame.
  - START: wait BIT_CYC/2 cycles, then sample rf. If rf=1 the start was a glitch: return to IDLE, no error.
  - DATA and PARITY: each bit sampled at bit centre, BIT_CYC cycles after the previous sample, shifted in LSB first.
  - STOP: sample rf. If stop=1 and parity OK, dout is loaded and dout_vld pulses 1 cycle.
  - On bad stop bit or parity mismatch: dout keeps its old value, no dout_vld, rx_err pulses 1 cycle.
  - Return to IDLE right after the stop sample (mid-stop bit), so back-to-back frames are caught.
  - dout_vld and rx_err are never high in the same cycle.
- TX and RX run fully concurrently and independently.

Optional Feature:
- Macro UART_LOOPBACK_EN.
- Defined: the receiver input is internally tied to the transmitter output (the tx register ahead of the synchroniser). The rx port is ignored; the tx pin still drives normally.
- Undefined: the receiver uses the rx port.

Decomposition:
- Package uart_pkg:
  - function bit_cycles(clk_freq, baud_rate) with the rounding rule above;
  - counter-width constant via $clog2;
  - enums tx_state_t and rx_state_t (IDLE, START, DATA, PARITY, STOP).
- One sub-module: uart_majority_filter (parameter M_TAPS; ports clk, rst, din, dout), instantiated on the synchronised rx.

Test Plan (defaults, two instances with tx/rx cross-connected):
- Reset release → tx=1, rfd=1, dout_vld=0, rx_err=0. Single din=8'd100 with din_vld=1 for one cycle → tx low for 109 cycles, then bits 0,0,1,0,0,1,1,0 at 109 cycles each, stop 1. Peer dout=100 with one dout_vld pulse about 9.5 bit periods after the start edge.
- din_vld held 1 with din=100 → consecutive frames separated by one rfd-high cycle; peer sees repeated dout_vld with dout=100, rx_err never 1.
- PARITY=1, din=8'h07 → parity bit 1 after data; peer dout=0x07. Force the parity bit inverted on the line → rx_err pulse, no dout_vld, dout unchanged.
- Drive the stop bit to 0 on rx → rx_err 1-cycle pulse, FSM back to IDLE, next good frame received correctly.
- 1-cycle low glitch on rx while idle → no frame started, no dout_vld, no rx_err. Glitch shorter than BIT_CYC/2 → START rejects it.
- Assert rst mid-TX-frame → tx=1 and rfd=1 immediately. After release, a new din=8'hA5 transmits cleanly.
